// File: rtl/pd_debug_pkg.sv
// Shared types and constants for the debug capture sequencer:
// capture state encoding, CSR word offsets and CTRL/STATUS bit positions.
package pd_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } cap_state_e;

    localparam logic [1:0] CSR_CTRL    = 2'd0;
    localparam logic [1:0] CSR_POSTCNT = 2'd1;
    localparam logic [1:0] CSR_STATUS  = 2'd2;
    localparam logic [1:0] CSR_PTR     = 2'd3;

    localparam int BIT_ARM      = 0;
    localparam int BIT_ABORT    = 1;
    localparam int BIT_IRQ_PEND = 3;

    localparam int POST_RST_DEF = 8;

endpackage

// File: rtl/pd_debug_csr.sv
// CSR slave: POSTCNT register, registered read mux, ARM/ABORT/IRQ-clear pulses.
// Ports: clk, reset_n, csr_* (Avalon-MM), core status in, arm/abort/irq_clr/postcnt out.
module pd_debug_csr
    import pd_debug_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int POST_RST = POST_RST_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    input  cap_state_e        state,
    input  logic              wrapped,
    input  logic              irq_pend,
    input  logic [ADDR_W-1:0] wr_ptr,
    input  logic [ADDR_W-1:0] trig_addr,
    output logic              arm,
    output logic              abort,
    output logic              irq_clr,
    output logic [ADDR_W-1:0] postcnt
);

    logic        wr_ctrl;
    logic        wr_status;
    logic        wr_postcnt;
    logic        cfg_ok;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign wr_ctrl    = csr_write && (csr_address == CSR_CTRL);
    assign wr_status  = csr_write && (csr_address == CSR_STATUS);
    assign wr_postcnt = csr_write && (csr_address == CSR_POSTCNT);

    // Pulses act in the same cycle as the write, so an ABORT
    // suppresses a sample presented alongside it.
    assign arm     = wr_ctrl && csr_writedata[BIT_ARM];
    assign abort   = wr_ctrl && csr_writedata[BIT_ABORT];
    assign irq_clr = wr_status && csr_writedata[BIT_IRQ_PEND];

    // POSTCNT is frozen while a capture is in flight.
    assign cfg_ok = (state == ST_IDLE) || (state == ST_DONE);

    assign unused_wdata = ^csr_writedata[31:ADDR_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            postcnt <= ADDR_W'(POST_RST);
        end else if (wr_postcnt && cfg_ok) begin
            postcnt <= csr_writedata[ADDR_W-1:0];
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (csr_address)
            CSR_CTRL: rd_mux = '0;
            CSR_POSTCNT: rd_mux[ADDR_W-1:0] = postcnt;
            CSR_STATUS: begin
                rd_mux[1:0]          = state;
                rd_mux[2]            = wrapped;
                rd_mux[BIT_IRQ_PEND] = irq_pend;
            end
            CSR_PTR: begin
                rd_mux[ADDR_W-1:0] = wr_ptr;
                rd_mux[8 +: ADDR_W] = trig_addr;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_readdata <= '0;
        end else if (csr_read) begin
            csr_readdata <= rd_mux;
        end
    end

endmodule

// File: rtl/pd_debug_capture_ctrl.sv
// Capture sequencer: streams samples into debug RAM port 2 as a circular
// pre/post-trigger buffer. Ports: clk, reset_n, sample_*, trigger, csr_*, ram_*, done_irq.
module pd_debug_capture_ctrl
    import pd_debug_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int POST_RST = POST_RST_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              trigger,
    input  logic [1:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_writedata,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic              done_irq
);

    cap_state_e        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] post_rem;
    logic              wrapped;
    logic              irq_pend;

    logic              arm;
    logic              abort;
    logic              irq_clr;
    logic [ADDR_W-1:0] postcnt;
    logic              capturing;
    logic              accept;

    pd_debug_csr #(
        .ADDR_W   (ADDR_W),
        .POST_RST (POST_RST)
    ) u_csr (
        .clk           (clk),
        .reset_n       (reset_n),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .state         (state),
        .wrapped       (wrapped),
        .irq_pend      (irq_pend),
        .wr_ptr        (wr_ptr),
        .trig_addr     (trig_addr),
        .arm           (arm),
        .abort         (abort),
        .irq_clr       (irq_clr),
        .postcnt       (postcnt)
    );

    assign ram_byteenable = 4'hF;
    assign done_irq       = irq_pend;

    assign capturing = (state == ST_PRE) || (state == ST_POST);
    assign accept    = sample_valid && capturing && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            wr_ptr         <= '0;
            trig_addr      <= '0;
            post_rem       <= '0;
            wrapped        <= 1'b0;
            irq_pend       <= 1'b0;
            ram_address    <= '0;
            ram_writedata  <= '0;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
        end else begin
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;

            // Later assignments in this block override, so an IRQ
            // set in the same cycle beats the clear.
            if (irq_clr) begin
                irq_pend <= 1'b0;
            end

            if (accept) begin
                ram_chipselect <= 1'b1;
                ram_write      <= 1'b1;
                ram_address    <= wr_ptr;
                ram_writedata  <= sample_data;
                wr_ptr         <= wr_ptr + ADDR_W'(1);
                if (wr_ptr == ADDR_W'(DEPTH - 1)) begin
                    wrapped <= 1'b1;
                end
            end

            if (abort) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE, ST_DONE: begin
                        if (arm) begin
                            state    <= ST_PRE;
                            wr_ptr   <= '0;
                            wrapped  <= 1'b0;
                            irq_pend <= 1'b0;
                        end
                    end
                    ST_PRE: begin
                        if (sample_valid && trigger) begin
                            trig_addr <= wr_ptr;
                            post_rem  <= postcnt;
                            if (postcnt == '0) begin
                                state    <= ST_DONE;
                                irq_pend <= 1'b1;
                            end else begin
                                state <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (sample_valid) begin
                            post_rem <= post_rem - ADDR_W'(1);
                            if (post_rem == ADDR_W'(1)) begin
                                state    <= ST_DONE;
                                irq_pend <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pd_debug_capture_ctrl.sv
// Directed bench for pd_debug_capture_ctrl with a shadow RAM on port 2.
// Ports: none (top-level bench).
module tb_pd_debug_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_valid;
    logic [31:0] sample_data;
    logic        trigger;
    logic [1:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic [31:0] csr_readdata;
    logic [3:0]  ram_address;
    logic [31:0] ram_writedata;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic        done_irq;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] mem [16];
    int          log_addr [$];
    logic [31:0] log_data [$];
    logic [31:0] rd;

    always #5 clk = ~clk;

    pd_debug_capture_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .trigger        (trigger),
        .csr_address    (csr_address),
        .csr_read       (csr_read),
        .csr_write      (csr_write),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .ram_address    (ram_address),
        .ram_writedata  (ram_writedata),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .done_irq       (done_irq)
    );

    always @(negedge clk) begin
        if (reset_n && ram_write && ram_chipselect) begin
            mem[ram_address] = ram_writedata;
            log_addr.push_back(int'(ram_address));
            log_data.push_back(ram_writedata);
        end
    end

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic csr_wr(logic [1:0] a, logic [31:0] d);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        @(posedge clk);
        #1;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(logic [1:0] a, output logic [31:0] d);
        csr_address = a;
        csr_read    = 1'b1;
        @(posedge clk);
        #1;
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic samp(logic [31:0] d, logic t);
        sample_valid = 1'b1;
        sample_data  = d;
        trigger      = t;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        trigger      = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        reset_n       = 1'b0;
        sample_valid  = 1'b0;
        sample_data   = '0;
        trigger       = 1'b0;
        csr_address   = '0;
        csr_read      = 1'b0;
        csr_write     = 1'b0;
        csr_writedata = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // 1: reset state
        idle(2);
        chk("rst_irq", 32'(done_irq), 32'd0);
        chk("rst_wr", 32'(ram_write), 32'd0);
        chk("rst_cs", 32'(ram_chipselect), 32'd0);
        chk("rst_be", 32'(ram_byteenable), 32'hF);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        csr_rd(2'd2, rd); chk("rst_status", rd, 32'h0);
        csr_rd(2'd3, rd); chk("rst_ptr", rd, 32'h0);
        csr_rd(2'd1, rd); chk("rst_postcnt", rd, 32'h8);
        csr_rd(2'd0, rd); chk("rst_ctrl", rd, 32'h0);

        // 2: basic capture, POSTCNT=3
        clr_log();
        csr_wr(2'd1, 32'd3);
        csr_wr(2'd0, 32'h1);
        chk("t2_wr_idle", 32'(ram_write), 32'd0);
        samp(32'hA0, 1'b0);
        chk("t2_lat_wr", 32'(ram_write), 32'd1);
        chk("t2_lat_cs", 32'(ram_chipselect), 32'd1);
        chk("t2_lat_addr", 32'(ram_address), 32'd0);
        chk("t2_lat_data", ram_writedata, 32'hA0);
        samp(32'hA1, 1'b0);
        samp(32'hA2, 1'b1);
        samp(32'hA3, 1'b0);
        samp(32'hA4, 1'b0);
        csr_rd(2'd2, rd); chk("t2_post", rd, 32'h2);
        samp(32'hA5, 1'b0);
        idle(2);
        csr_rd(2'd2, rd); chk("t2_status", rd, 32'hB);
        csr_rd(2'd3, rd); chk("t2_ptr", rd, 32'h206);
        chk("t2_irq", 32'(done_irq), 32'd1);
        chk("t2_nwr", 32'(log_addr.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_addr.size()) begin
                chk("t2_addr", 32'(log_addr[i]), 32'(i));
                chk("t2_data", log_data[i], 32'hA0 + 32'(i));
            end
        end

        // 3: wrap-around, POSTCNT=2
        clr_log();
        csr_wr(2'd1, 32'd2);
        csr_wr(2'd0, 32'h1);
        chk("t3_irq_arm", 32'(done_irq), 32'd0);
        for (int i = 0; i < 20; i++)
            samp(32'h100 + 32'(i), i == 17);
        idle(2);
        csr_rd(2'd2, rd); chk("t3_status", rd, 32'hF);
        csr_rd(2'd3, rd); chk("t3_ptr", rd, 32'h104);
        chk("t3_nwr", 32'(log_addr.size()), 32'd20);
        chk("t3_mem3", mem[3], 32'h113);
        chk("t3_mem1", mem[1], 32'h111);
        chk("t3_mem4", mem[4], 32'h104);

        // 4: POSTCNT=0, trigger on first sample
        clr_log();
        csr_wr(2'd1, 32'd0);
        csr_wr(2'd0, 32'h1);
        samp(32'h55, 1'b1);
        csr_rd(2'd2, rd); chk("t4_status", rd, 32'hB);
        chk("t4_irq", 32'(done_irq), 32'd1);
        chk("t4_nwr", 32'(log_addr.size()), 32'd1);
        chk("t4_mem0", mem[0], 32'h55);
        csr_wr(2'd2, 32'h8);
        chk("t4_irq_clr", 32'(done_irq), 32'd0);
        csr_rd(2'd2, rd); chk("t4_status2", rd, 32'h3);

        // 5: re-ARM in PRE ignored, ABORT with 6th sample
        clr_log();
        csr_wr(2'd0, 32'h1);
        samp(32'hC0, 1'b0);
        samp(32'hC1, 1'b0);
        samp(32'hC2, 1'b0);
        csr_wr(2'd0, 32'h1);
        csr_wr(2'd1, 32'd9);
        samp(32'hC3, 1'b0);
        samp(32'hC4, 1'b0);
        sample_valid  = 1'b1;
        sample_data   = 32'hC5;
        csr_address   = 2'd0;
        csr_writedata = 32'h3;
        csr_write     = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        csr_write    = 1'b0;
        idle(2);
        csr_rd(2'd2, rd); chk("t5_status", rd, 32'h0);
        csr_rd(2'd3, rd); chk("t5_ptr", rd, 32'h005);
        csr_rd(2'd1, rd); chk("t5_postcnt", rd, 32'h0);
        chk("t5_nwr", 32'(log_addr.size()), 32'd5);
        if (log_addr.size() == 5) begin
            chk("t5_last_addr", 32'(log_addr[4]), 32'd4);
            chk("t5_last_data", log_data[4], 32'hC4);
        end

        // 6: async reset mid-POST with a write pending
        csr_wr(2'd1, 32'd5);
        csr_wr(2'd0, 32'h1);
        samp(32'hD0, 1'b1);
        samp(32'hD1, 1'b0);
        csr_rd(2'd2, rd); chk("t6_post", rd, 32'h2);
        sample_valid = 1'b1;
        sample_data  = 32'hD2;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        chk("t6_pend", 32'(ram_write), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_wr", 32'(ram_write), 32'd0);
        chk("t6_cs", 32'(ram_chipselect), 32'd0);
        chk("t6_addr", 32'(ram_address), 32'd0);
        chk("t6_data", ram_writedata, 32'd0);
        chk("t6_rdata", csr_readdata, 32'd0);
        chk("t6_be", 32'(ram_byteenable), 32'hF);
        chk("t6_irq", 32'(done_irq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        clr_log();
        samp(32'hE0, 1'b1);
        samp(32'hE1, 1'b0);
        samp(32'hE2, 1'b0);
        idle(2);
        chk("t6_nowr", 32'(log_addr.size()), 32'd0);
        csr_rd(2'd1, rd); chk("t6_postcnt", rd, 32'h8);
        csr_rd(2'd2, rd); chk("t6_status", rd, 32'h0);
        csr_rd(2'd3, rd); chk("t6_ptr", rd, 32'h0);
        csr_wr(2'd0, 32'h1);
        samp(32'hF0, 1'b0);
        idle(1);
        chk("t6_nwr", 32'(log_addr.size()), 32'd1);
        chk("t6_mem0", mem[0], 32'hF0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pd_debug_capture_ctrl.md
Name: pd_debug_capture_ctrl

Overview:
Capture sequencer for the pattern-generator debug RAM (16 x 32-bit, dual-port). It owns RAM port 2 and streams pattern-generator samples into the RAM as a circular pre/post-trigger buffer. A small Avalon-MM CSR slave lets the CPU arm, abort and read status. The CPU reads captured data through RAM port 1, which this block does not touch.

Parameters:
DEPTH, 16, RAM words; power of two; must match the RAM numwords.
ADDR_W, 4, log2(DEPTH); must match the RAM address width.
DATA_W, 32, sample and RAM word width.
POST_RST, 8, reset value of the POSTCNT register.

Ports:
clk  in  1  system clock; RAM port 2 shares this clock.
reset_n  in  1  asynchronous, active-low reset.
sample_valid  in  1  sample strobe from the pattern generator.
sample_data  in  DATA_W  sample word.
trigger  in  1  trigger qualifier; honoured only when sample_valid=1.
csr_address  in  2  CSR word address.
csr_read  in  1  Avalon read.
csr_write  in  1  Avalon write.
csr_writedata  in  32  Avalon write data.
csr_readdata  out  32  Avalon read data; fixed read latency of 1.
ram_address  out  ADDR_W  to RAM address2.
ram_writedata  out  DATA_W  to RAM writedata2.
ram_byteenable  out  4  to RAM byteenable2; constant 4'hF.
ram_chipselect  out  1  to RAM chipselect2.
ram_write  out  1  to RAM write2.
done_irq  out  1  level interrupt; high while IRQ_PEND=1.

Behaviour:
Reset values:
- All outputs 0, except ram_byteenable=4'hF.
- state=IDLE, wr_ptr=0, trig_addr=0, post_rem=0, wrapped=0, IRQ_PEND=0, POSTCNT=POST_RST.

CSR map (32-bit words; unused bits read 0, writes to them ignored):
- 0 CTRL: write-only, reads return 0.
  - bit0 ARM: one-cycle pulse.
  - bit1 ABORT: one-cycle pulse.
- 1 POSTCNT: R/W, bits [ADDR_W-1:0]. Number of samples captured after the trigger sample. Writes take effect only in IDLE or DONE.
- 2 STATUS: read-only except bit3.
  - [1:0] state: IDLE=0, PRE=1, POST=2, DONE=3.
  - [2] wrapped.
  - [3] IRQ_PEND; writing 1 clears it.
- 3 PTR: read-only.
  - [ADDR_W-1:0] wr_ptr, the next address to be written.
  - [8+ADDR_W-1:8] trig_addr.
- csr_readdata is registered: valid the cycle after csr_read. It holds its value when no read is in progress.

State machine:
- IDLE: ARM -> PRE. On that transition: wr_ptr=0, wrapped=0, IRQ_PEND=0.
- PRE: each sample_valid writes one word.
  - trigger=1 with sample_valid: trig_addr=wr_ptr, post_rem=POSTCNT.
  - Then go to DONE if POSTCNT=0, otherwise to POST.
- POST: each sample_valid writes one word and decrements post_rem.
  - When a write occurs with post_rem=1: go to DONE and set IRQ_PEND.
  - trigger is ignored in POST.
- DONE: no RAM writes. ARM -> PRE, with the same initialisation as from IDLE.
- ABORT in any state -> IDLE. ABORT leaves wr_ptr, trig_addr, wrapped and IRQ_PEND unchanged.
- Entering DONE directly from PRE (POSTCNT=0) also sets IRQ_PEND.

RAM write timing:
- An accepted sample drives ram_chipselect=ram_write=1 for exactly one cycle, starting the cycle after sample_valid (registered, latency 1).
- In that cycle ram_address holds the pre-increment wr_ptr and ram_writedata holds sample_data.
- Otherwise ram_chipselect=ram_write=0.
- Back-to-back sample_valid gives back-to-back writes, one per clock.

Pointer arithmetic:
- wr_ptr increments modulo DEPTH on every accepted sample.
- On the DEPTH-1 -> 0 wrap: wrapped=1; it stays set until the next ARM.
- Oldest valid word: wrapped ? wr_ptr : 0 (read by software after DONE).

Simultaneous events:
- ABORT and ARM in the same write: ABORT wins -> IDLE.
- ARM while in PRE or POST: ignored.
- A sample in the cycle ABORT is written is not captured.
- An IRQ_PEND clear and an IRQ set in the same cycle: set wins.
- POSTCNT greater than DEPTH-1 is impossible (field width). A POSTCNT large enough to overwrite the trigger word is allowed; software interprets the result.

Reset mid-capture: asynchronous return to the reset values; any pending RAM write is dropped.

Decomposition:
- Package pd_debug_pkg:
  - state enum: IDLE, PRE, POST, DONE.
  - CSR offsets: CTRL=0, POSTCNT=1, STATUS=2, PTR=3.
  - Bit positions: ARM=0, ABORT=1, IRQ_PEND=3.
  - POST_RST default.
- One sub-module: pd_debug_csr. It holds the register file, the read mux and the pulse generation, and exports arm, abort, irq_clr and postcnt to the FSM/pointer core in the top module.

Test Plan:
1. Reset, then read all CSRs -> STATUS=0, PTR=0, POSTCNT=8; done_irq=0; ram_write=0; ram_byteenable=4'hF.
2. POSTCNT=3, ARM; samples 0xA0..0xA4 with trigger on 0xA2 -> writes at addr 0..5 (0xA0..0xA5 with a sixth sample); DONE after 0xA5; trig_addr=2; wr_ptr=6; done_irq=1.
3. POSTCNT=2, ARM; 20 samples 0x100+i with trigger on i=17 -> wrapped=1; trig_addr=1; DONE after i=19; wr_ptr=4; RAM addr 3 holds 0x113.
4. POSTCNT=0, ARM; trigger on the first sample 0x55 -> one write at addr 0; state DONE the next cycle; IRQ_PEND=1; write STATUS=0x8 -> done_irq=0.
5. ARM, 5 samples, ABORT written in the same cycle as sample 6 -> state IDLE; wr_ptr=5; sample 6 not written; a further ARM in PRE is ignored until after ABORT.
6. Deassert reset_n mid-POST with a write pending -> outputs return to reset values asynchronously; no ram_write is asserted after reset release until the next ARM plus sample.
